hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV core; companion to the EX operand-forwarding logic.
- Detects load-use hazards that forwarding cannot cover.
- Sequences the multi-cycle EX unit (mul/div) through a start/done handshake.
- Freezes the pipeline on data-memory wait and squashes wrong-path instructions on redirect.
- Drives per-stage pipeline register stall/flush controls and the PC enable.

---
 rtl/hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RV core.
//   Detects load-use hazards, sequences the multi-cycle EX unit (mul/div),
//   freezes the pipeline on data-memory wait and squashes wrong-path work.
// Ports:
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_id_* / i_ex_*         : ID source registers and EX destination/load/redirect/mc info
//   i_mc_done, i_mem_req,
//   i_dmem_ready            : multi-cycle unit result and MEM-stage access status
//   o_*_stall / o_*_flush   : per-stage pipeline register hold / bubble controls
//   o_mc_start, o_mc_ack    : multi-cycle unit handshake
//   o_mc_timeout            : sticky, MC_WAIT lasted MC_TIMEOUT cycles
//   o_state                 : 0=RUN, 1=MC_WAIT
//   o_stall_cnt/o_flush_cnt : perf counters, live only when HAZARD_PERF_EN is defined
// Optional feature macro: HAZARD_PERF_EN (undefined: counters read 0, no counter flops).
module hazard_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int PERF_W     = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [4:0]        i_id_rs1,
   input  logic [4:0]        i_id_rs2,
   input  logic              i_id_use_rs1,
   input  logic              i_id_use_rs2,
   input  logic [4:0]        i_ex_rd,
   input  logic              i_ex_mem_re,
   input  logic              i_ex_redirect,
   input  logic              i_ex_mc_valid,
   input  logic              i_mc_done,
   input  logic              i_mem_req,
   input  logic              i_dmem_ready,
   output logic              o_pc_stall,
   output logic              o_if_id_stall,
   output logic              o_id_ex_stall,
   output logic              o_ex_mem_stall,
   output logic              o_if_id_flush,
   output logic              o_id_ex_flush,
   output logic              o_ex_mem_flush,
   output logic              o_mem_wb_flush,
   output logic              o_mc_start,
   output logic              o_mc_ack,
   output logic              o_mc_timeout,
   output logic [1:0]        o_state,
   output logic [PERF_W-1:0] o_stall_cnt,
   output logic [PERF_W-1:0] o_flush_cnt
);

   localparam int TW = $clog2(MC_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(MC_TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MC_WAIT = 2'd1
   } state_t;

   state_t        state;
   logic [TW-1:0] to_cnt;
   logic          mc_timeout_q;
   logic          mem_stall;
   logic          load_use;

   assign mem_stall = i_mem_req & ~i_dmem_ready;

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = i_ex_mem_re & (i_ex_rd != 5'd0) &
                     ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                      (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

   always_comb begin
      o_pc_stall     = 1'b0;
      o_if_id_stall  = 1'b0;
      o_id_ex_stall  = 1'b0;
      o_ex_mem_stall = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_flush  = 1'b0;
      o_ex_mem_flush = 1'b0;
      o_mem_wb_flush = 1'b0;
      o_mc_start     = 1'b0;
      o_mc_ack       = 1'b0;
      if (!i_rst) begin
         if (mem_stall) begin
            // Whole pipeline freezes; WB gets a bubble while MEM waits.
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_stall = 1'b1;
            o_mem_wb_flush = 1'b1;
         end else if (state == ST_RUN) begin
            if (i_ex_mc_valid) begin
               o_mc_start     = 1'b1;
               o_pc_stall     = 1'b1;
               o_if_id_stall  = 1'b1;
               o_id_ex_stall  = 1'b1;
               o_ex_mem_flush = 1'b1;
            end else if (i_ex_redirect) begin
               // Squashing ID makes any load-use on it irrelevant.
               o_if_id_flush = 1'b1;
               o_id_ex_flush = 1'b1;
            end else if (load_use) begin
               o_pc_stall    = 1'b1;
               o_if_id_stall = 1'b1;
               o_id_ex_flush = 1'b1;
            end
         end else begin
            if (i_mc_done) begin
               o_mc_ack = 1'b1;
            end else begin
               o_pc_stall     = 1'b1;
               o_if_id_stall  = 1'b1;
               o_id_ex_stall  = 1'b1;
               o_ex_mem_flush = 1'b1;
            end
         end
      end
   end

   // State, wait counter and sticky timeout all hold while memory stalls,
   // so a pending i_mc_done is only acked once the freeze lifts.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= ST_RUN;
         to_cnt       <= '0;
         mc_timeout_q <= 1'b0;
      end else if (!mem_stall) begin
         case (state)
            ST_RUN: begin
               if (i_ex_mc_valid) begin
                  state  <= ST_MC_WAIT;
                  to_cnt <= '0;
               end
            end
            ST_MC_WAIT: begin
               if (i_mc_done) begin
                  state <= ST_RUN;
               end else begin
                  if (to_cnt != TO_MAX) begin
                     to_cnt <= to_cnt + TW'(1);
                  end
                  if (to_cnt == TO_MAX - TW'(1)) begin
                     mc_timeout_q <= 1'b1;
                  end
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   assign o_state      = state;
   assign o_mc_timeout = mc_timeout_q;

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_cnt_q;
   logic [PERF_W-1:0] flush_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (o_pc_stall) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
         end
         if (o_if_id_flush) begin
            flush_cnt_q <= flush_cnt_q + PERF_W'(1);
         end
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int T      = 4;
   localparam int PERF_W = 32;
`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Output vector bit order: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
   // if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mc_start, mc_ack
   localparam logic [9:0] V_NONE  = 10'b0000000000;
   localparam logic [9:0] V_LU    = 10'b1100010000;
   localparam logic [9:0] V_REDIR = 10'b0000110000;
   localparam logic [9:0] V_START = 10'b1110001010;
   localparam logic [9:0] V_WAIT  = 10'b1110001000;
   localparam logic [9:0] V_ACK   = 10'b0000000001;
   localparam logic [9:0] V_MEM   = 10'b1111000100;

   logic i_clk = 1'b0;
   logic i_rst;
   logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd;
   logic i_id_use_rs1, i_id_use_rs2, i_ex_mem_re, i_ex_redirect, i_ex_mc_valid;
   logic i_mc_done, i_mem_req, i_dmem_ready;
   logic o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall;
   logic o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush;
   logic o_mc_start, o_mc_ack, o_mc_timeout;
   logic [1:0] o_state;
   logic [PERF_W-1:0] o_stall_cnt, o_flush_cnt;
   logic [9:0] obs;

   assign obs = {o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall,
                 o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
                 o_mc_start, o_mc_ack};

   hazard_ctrl #(.MC_TIMEOUT(T), .PERF_W(PERF_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
      .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
      .i_ex_rd(i_ex_rd), .i_ex_mem_re(i_ex_mem_re),
      .i_ex_redirect(i_ex_redirect), .i_ex_mc_valid(i_ex_mc_valid),
      .i_mc_done(i_mc_done), .i_mem_req(i_mem_req), .i_dmem_ready(i_dmem_ready),
      .o_pc_stall(o_pc_stall), .o_if_id_stall(o_if_id_stall),
      .o_id_ex_stall(o_id_ex_stall), .o_ex_mem_stall(o_ex_mem_stall),
      .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
      .o_ex_mem_flush(o_ex_mem_flush), .o_mem_wb_flush(o_mem_wb_flush),
      .o_mc_start(o_mc_start), .o_mc_ack(o_mc_ack), .o_mc_timeout(o_mc_timeout),
      .o_state(o_state), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: "waiting on the multi-cycle unit", cycles waited,
   // sticky timeout, and cycle counts for the perf counters.
   bit          m_wait;
   int          m_waited;
   bit          m_to;
   int unsigned m_scnt, m_fcnt;
   logic [9:0]  m_exp;

   function automatic logic [9:0] model_out();
      bit ms, lu;
      ms = i_mem_req && !i_dmem_ready;
      lu = i_ex_mem_re && (i_ex_rd != 0) &&
           ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) || (i_id_use_rs2 && i_id_rs2 == i_ex_rd));
      if (i_rst)                return V_NONE;
      if (ms)                   return V_MEM;
      if (m_wait)               return i_mc_done ? V_ACK : V_WAIT;
      if (i_ex_mc_valid)        return V_START;
      if (i_ex_redirect)        return V_REDIR;
      if (lu)                   return V_LU;
      return V_NONE;
   endfunction

   task automatic model_reset();
      m_wait = 0; m_waited = 0; m_to = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic settle();
      #1;
      if (i_rst) model_reset();
      m_exp = model_out();
   endtask

   task automatic advance();
      bit ms;
      ms = i_mem_req && !i_dmem_ready;
      @(posedge i_clk);
      if (i_rst) begin
         model_reset();
      end else begin
         if (m_exp[9]) m_scnt++;
         if (m_exp[5]) m_fcnt++;
         if (!ms) begin
            if (!m_wait) begin
               if (i_ex_mc_valid) begin m_wait = 1; m_waited = 0; end
            end else if (i_mc_done) begin
               m_wait = 0;
            end else begin
               if (m_waited < T) m_waited++;
               if (m_waited >= T) m_to = 1;
            end
         end
      end
      @(negedge i_clk);
   endtask

   task automatic idle();
      i_id_rs1 = 0; i_id_rs2 = 0; i_id_use_rs1 = 0; i_id_use_rs2 = 0;
      i_ex_rd = 0; i_ex_mem_re = 0; i_ex_redirect = 0; i_ex_mc_valid = 0;
      i_mc_done = 0; i_mem_req = 0; i_dmem_ready = 1;
   endtask

   task automatic test_reset();
      i_rst = 0; idle();
      #2 i_rst = 1;
      settle();
      total++;
      if (obs !== V_NONE || o_state !== 2'd0 || o_mc_timeout !== 1'b0) begin
         bad++; $display("FAIL reset_hold got=%b/%0d/%b exp=%b/0/0", obs, o_state, o_mc_timeout, V_NONE);
      end
      total++;
      if (o_stall_cnt !== 0 || o_flush_cnt !== 0) begin
         bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", o_stall_cnt, o_flush_cnt);
      end
      // Even with a load-use hazard present, reset forces the controls low.
      i_ex_mem_re = 1; i_ex_rd = 3; i_id_rs1 = 3; i_id_use_rs1 = 1;
      settle();
      total++;
      if (obs !== V_NONE) begin
         bad++; $display("FAIL reset_gates got=%b exp=%b", obs, V_NONE);
      end
      advance();
      i_rst = 0; idle();
      settle();
      total++;
      if (obs !== V_NONE || o_state !== 2'd0) begin
         bad++; $display("FAIL reset_release got=%b/%0d exp=%b/0", obs, o_state, V_NONE);
      end
      advance();
   endtask

   task automatic reset_dut();
      i_rst = 1; idle();
      settle();
      advance();
      i_rst = 0;
   endtask

   task automatic test_load_use();
      idle();
      i_ex_mem_re = 1; i_ex_rd = 5; i_id_rs2 = 5; i_id_use_rs2 = 1; i_id_rs1 = 7; i_id_use_rs1 = 1;
      settle();
      total++;
      if (obs !== V_LU) begin bad++; $display("FAIL load_use_rs2 got=%b exp=%b", obs, V_LU); end
      advance();
      i_ex_rd = 0; i_id_rs2 = 0;
      settle();
      total++;
      if (obs !== V_NONE) begin bad++; $display("FAIL load_use_x0 got=%b exp=%b", obs, V_NONE); end
      advance();
      i_ex_rd = 9; i_id_rs1 = 9; i_id_use_rs1 = 0; i_id_rs2 = 2;
      settle();
      total++;
      if (obs !== V_NONE) begin bad++; $display("FAIL load_use_unused got=%b exp=%b", obs, V_NONE); end
      advance();
      i_ex_mem_re = 0; i_id_use_rs1 = 1;
      settle();
      total++;
      if (obs !== V_NONE) begin bad++; $display("FAIL load_use_not_load got=%b exp=%b", obs, V_NONE); end
      advance();
      idle();
   endtask

   task automatic test_redirect();
      idle();
      i_ex_redirect = 1; i_ex_mem_re = 1; i_ex_rd = 12; i_id_rs1 = 12; i_id_use_rs1 = 1;
      settle();
      total++;
      if (obs !== V_REDIR) begin bad++; $display("FAIL redirect_lu got=%b exp=%b", obs, V_REDIR); end
      advance();
      idle();
   endtask

   task automatic test_mc_seq();
      idle();
      i_ex_mc_valid = 1;
      settle();
      total++;
      if (obs !== V_START || o_state !== 2'd0) begin
         bad++; $display("FAIL mc_start got=%b/%0d exp=%b/0", obs, o_state, V_START);
      end
      advance();
      for (int c = 1; c <= 4; c++) begin
         settle();
         total++;
         if (obs !== V_WAIT || o_state !== 2'd1) begin
            bad++; $display("FAIL mc_wait_c%0d got=%b/%0d exp=%b/1", c, obs, o_state, V_WAIT);
         end
         advance();
      end
      i_mc_done = 1;
      settle();
      total++;
      if (obs !== V_ACK) begin bad++; $display("FAIL mc_ack got=%b exp=%b", obs, V_ACK); end
      advance();
      idle();
      settle();
      total++;
      if (obs !== V_NONE || o_state !== 2'd0) begin
         bad++; $display("FAIL mc_back_run got=%b/%0d exp=%b/0", obs, o_state, V_NONE);
      end
      advance();
   endtask

   task automatic test_mc_mem_stall();
      idle();
      i_ex_mc_valid = 1;
      settle();
      advance();
      i_mc_done = 1; i_mem_req = 1; i_dmem_ready = 0;
      for (int c = 0; c < 3; c++) begin
         settle();
         total++;
         if (obs !== V_MEM || o_state !== 2'd1) begin
            bad++; $display("FAIL mc_memstall_c%0d got=%b/%0d exp=%b/1", c, obs, o_state, V_MEM);
         end
         advance();
      end
      i_dmem_ready = 1;
      settle();
      total++;
      if (obs !== V_ACK) begin bad++; $display("FAIL mc_ack_after_mem got=%b exp=%b", obs, V_ACK); end
      advance();
      idle();
      settle();
      total++;
      if (o_state !== 2'd0) begin bad++; $display("FAIL mc_mem_back_run got=%0d exp=0", o_state); end
      advance();
   endtask

   task automatic test_timeout();
      reset_dut();
      i_ex_mc_valid = 1;
      settle();
      advance();
      for (int c = 1; c <= T; c++) begin
         settle();
         total++;
         if (o_mc_timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_early_c%0d got=%b exp=0", c, o_mc_timeout);
         end
         advance();
      end
      for (int c = 0; c < 2; c++) begin
         settle();
         total++;
         if (o_mc_timeout !== 1'b1 || obs !== V_WAIT) begin
            bad++; $display("FAIL timeout_set_%0d got=%b/%b exp=1/%b", c, o_mc_timeout, obs, V_WAIT);
         end
         advance();
      end
      i_rst = 1;
      settle();
      total++;
      if (obs !== V_NONE || o_state !== 2'd0 || o_mc_timeout !== 1'b0) begin
         bad++; $display("FAIL timeout_reset got=%b/%0d/%b exp=%b/0/0", obs, o_state, o_mc_timeout, V_NONE);
      end
      advance();
      i_rst = 0; idle();
   endtask

   task automatic test_perf();
      reset_dut();
      for (int k = 0; k < 3; k++) begin
         idle(); i_ex_mem_re = 1; i_ex_rd = 6; i_id_rs1 = 6; i_id_use_rs1 = 1;
         settle(); advance();
         idle(); settle(); advance();
      end
      for (int k = 0; k < 2; k++) begin
         idle(); i_ex_redirect = 1;
         settle(); advance();
      end
      idle();
      settle();
      total++;
      if (o_stall_cnt !== (PERF ? 32'd3 : 32'd0) || o_flush_cnt !== (PERF ? 32'd2 : 32'd0)) begin
         bad++; $display("FAIL perf_counts got=%0d/%0d exp=%0d/%0d", o_stall_cnt, o_flush_cnt,
                         PERF ? 3 : 0, PERF ? 2 : 0);
      end
      advance();
   endtask

   task automatic test_random();
      reset_dut();
      for (int n = 0; n < 600; n++) begin
         i_rst         = ($urandom_range(99) == 0);
         i_id_rs1      = 5'($urandom_range(3));
         i_id_rs2      = 5'($urandom_range(3));
         i_ex_rd       = 5'($urandom_range(3));
         i_id_use_rs1  = 1'($urandom);
         i_id_use_rs2  = 1'($urandom);
         i_ex_mem_re   = 1'($urandom);
         i_ex_mc_valid = ($urandom_range(4) == 0);
         i_ex_redirect = !i_ex_mc_valid && ($urandom_range(3) == 0);
         i_mc_done     = ($urandom_range(5) == 0);
         i_mem_req     = 1'($urandom);
         i_dmem_ready  = ($urandom_range(2) != 0);
         settle();
         total++;
         if (obs !== m_exp || o_state !== {1'b0, m_wait} || o_mc_timeout !== m_to) begin
            bad++; $display("FAIL rand_%0d got=%b/%0d/%b exp=%b/%0d/%b", n, obs, o_state,
                            o_mc_timeout, m_exp, m_wait, m_to);
         end
         total++;
         if (o_stall_cnt !== (PERF ? m_scnt : 0) || o_flush_cnt !== (PERF ? m_fcnt : 0)) begin
            bad++; $display("FAIL rand_perf_%0d got=%0d/%0d exp=%0d/%0d", n, o_stall_cnt,
                            o_flush_cnt, PERF ? m_scnt : 0, PERF ? m_fcnt : 0);
         end
         advance();
      end
      i_rst = 0; idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_use();
      test_redirect();
      test_mc_seq();
      test_mc_mem_stall();
      test_timeout();
      test_perf();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
